// File: rtl/button_cond.sv
// Push-button conditioner: 2-flop sync, per-button debounce, one-cycle press pulse to the game FSM.
// Latency: raw edge -> level/B after MAX+3 clk edges; lock and multi-press squash B without stalling debounce.
module button_cond #(
    parameter int N = 21,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] btn_raw,
    input  logic         lock,
    output logic [W-1:0] level,
    output logic [W-1:0] B,
    output logic         multi
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    localparam logic [N-1:0] MAX = '1;

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [N-1:0] cnt [W];
    state_t       st  [W];

    logic [W-1:0] accept;
    logic [W-1:0] press;
    logic         two_plus;

    always_comb begin
        level  = '0;
        accept = '0;
        press  = '0;
        for (int i = 0; i < W; i++) begin
            level[i]  = (st[i] == PRESSED);
            accept[i] = (s2[i] != level[i]) && (cnt[i] == MAX);
            press[i]  = accept[i] && s2[i];
        end
        // Clearing the lowest set bit leaves something only if two or more were set.
        two_plus = (press & (press - W'(1))) != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            B     <= '0;
            multi <= 1'b0;
            for (int i = 0; i < W; i++) begin
                cnt[i] <= '0;
                st[i]  <= RELEASED;
            end
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            for (int i = 0; i < W; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else begin
                    st[i]  <= s2[i] ? PRESSED : RELEASED;
                    cnt[i] <= '0;
                end
            end
            B     <= (two_plus || lock) ? '0 : press;
            multi <= two_plus && !lock;
        end
    end

endmodule
